// File: rtl/hacd_reg_arbiter_if.sv
// Shared HACD register bus: NUM_REQ requester beats in, one register-file beat out.
// master = requesters and register file; slave = the arbiter between them.
interface hacd_reg_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*DW/8-1:0]   req_wstrb;
  logic [NUM_REQ*AW-1:0]     req_addr;
  logic [NUM_REQ*DW-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DW-1:0]     req_rdata;

  logic                      slv_valid;
  logic                      slv_write;
  logic [DW/8-1:0]           slv_wstrb;
  logic [AW-1:0]             slv_addr;
  logic [DW-1:0]             slv_wdata;
  logic                      slv_ready;
  logic [DW-1:0]             slv_rdata;

  modport master (
    output req_valid, req_write, req_lock, req_wstrb, req_addr, req_wdata,
    input  req_ready, req_rdata,
    input  slv_valid, slv_write, slv_wstrb, slv_addr, slv_wdata,
    output slv_ready, slv_rdata
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_wstrb, req_addr, req_wdata,
    output req_ready, req_rdata,
    output slv_valid, slv_write, slv_wstrb, slv_addr, slv_wdata,
    input  slv_ready, slv_rdata
  );
endinterface

// File: rtl/hacd_reg_arbiter.sv
// Round-robin arbiter sharing the HACD register port between requesters, with a per-beat
// lock so split 64-bit accesses stay atomic, and a watchdog that breaks a stalled lock.
module hacd_reg_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned LOCK_TIMEOUT = 16,
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hacd_reg_arbiter_if.slave     bus_if,
  output logic [IW-1:0]         gnt_idx_o,
  output logic                  lock_err_o,
  input  logic                  lock_err_clr_i
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TimerLast = (LOCK_TIMEOUT > 0) ? TW'(LOCK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLocked = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            lock_err_q, lock_err_d;

  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic            sel_hit;
  logic            grant;
  logic            accept;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (32'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Candidate selection: owner only while locked, otherwise first valid from rr_q onward.
  always_comb begin
    sel     = rr_q;
    sel_hit = 1'b0;
    cand    = '0;
    case (state_q)
      StLocked: begin
        sel     = owner_q;
        sel_hit = bus_if.req_valid[owner_q];
      end
      default: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          cand = IW'((32'(rr_q) + i) % NUM_REQ);
          if (!sel_hit && bus_if.req_valid[cand]) begin
            sel     = cand;
            sel_hit = 1'b1;
          end
        end
      end
    endcase
  end

  // Zero-latency pass-through of the selected beat; everything is muted under reset.
  always_comb begin
    grant            = sel_hit & ~rst_i;
    accept           = grant & bus_if.slv_ready;
    gnt_idx_o        = rst_i ? '0 : sel;
    bus_if.slv_valid = grant;
    bus_if.slv_write = grant & bus_if.req_write[sel];
    bus_if.slv_wstrb = grant ? bus_if.req_wstrb[32'(sel)*SW +: SW] : '0;
    bus_if.slv_addr  = grant ? bus_if.req_addr[32'(sel)*AW +: AW] : '0;
    bus_if.slv_wdata = grant ? bus_if.req_wdata[32'(sel)*DW +: DW] : '0;
    bus_if.req_ready = '0;
    bus_if.req_rdata = '0;
    if (!rst_i) begin
      bus_if.req_ready[sel]                = bus_if.slv_ready;
      bus_if.req_rdata[32'(sel)*DW +: DW]  = bus_if.slv_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    lock_err_d = lock_err_q & ~lock_err_clr_i;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rr_d = next_idx(sel);
          if (bus_if.req_lock[sel]) begin
            state_d = StLocked;
            owner_d = sel;
            timer_d = '0;
          end
        end
      end
      StLocked: begin
        if (accept) begin
          timer_d = '0;
          if (!bus_if.req_lock[owner_q]) begin
            state_d = StIdle;
            rr_d    = next_idx(owner_q);
          end
        end else begin
          if (timer_q != {TW{1'b1}}) timer_d = timer_q + 1'b1;
          // Fire on the last allowed idle cycle; setting lock_err wins over a same-cycle clear.
          if (LOCK_TIMEOUT != 0 && timer_q == TimerLast) begin
            state_d    = StIdle;
            lock_err_d = 1'b1;
            rr_d       = next_idx(owner_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      owner_q    <= '0;
      timer_q    <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign lock_err_o = lock_err_q;
endmodule

// File: tb/tb_hacd_reg_arbiter.sv
// Directed bench for hacd_reg_arbiter: a vector table for arbitration/mux, then lock,
// watchdog, stall and reset sequences.
module tb_hacd_reg_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LOCK_TIMEOUT = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic lock_err_clr_i = 1'b0;
  logic gnt_idx_o;
  logic lock_err_o;
  int   n_chk = 0;
  int   n_err = 0;

  hacd_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  hacd_reg_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bus_if         (bus),
    .gnt_idx_o      (gnt_idx_o),
    .lock_err_o     (lock_err_o),
    .lock_err_clr_i (lock_err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [31:0] a0, a1, wd0, wd1;
    logic [7:0]  wstrb;
    logic        sready;
    logic [31:0] srdata;
    logic        evalid, ewrite;
    logic [31:0] eaddr, ewdata;
    logic [3:0]  ewstrb;
    logic [1:0]  eready;
    logic        egnt;
    logic [31:0] erd0, erd1;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] valid, input logic [1:0] write, input logic [1:0] lock,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [7:0] wstrb, input logic sready, input logic [31:0] srdata);
    bus.req_valid = valid;
    bus.req_write = write;
    bus.req_lock  = lock;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {wd1, wd0};
    bus.req_wstrb = wstrb;
    bus.slv_ready = sready;
    bus.slv_rdata = srdata;
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  initial begin
    //          valid  write  a0     a1     wd0           wd1           wstrb  rdy srdata
    //          evalid ewrite eaddr  ewdata        ewstrb eready egnt erd0          erd1
    tbl[0] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h1111_1111,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 1'b0, 32'h1111_1111, 32'h0};
    tbl[1] = '{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'hCAFE_0001,
               1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 2'b01, 1'b0, 32'hCAFE_0001, 32'h0};
    tbl[2] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 1'b1, 32'h0, 32'h0};
    tbl[3] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 8'h00, 1'b1, 32'hA5A5_0003,
               1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 2'b10, 1'b1, 32'h0, 32'hA5A5_0003};
    tbl[4] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 8'h00, 1'b1, 32'hA5A5_0004,
               1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 2'b01, 1'b0, 32'hA5A5_0004, 32'h0};
    tbl[5] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 8'h00, 1'b1, 32'hA5A5_0005,
               1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 2'b10, 1'b1, 32'h0, 32'hA5A5_0005};
    tbl[6] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 8'h00, 1'b1, 32'hA5A5_0006,
               1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 2'b01, 1'b0, 32'hA5A5_0006, 32'h0};
    tbl[7] = '{2'b10, 2'b10, 32'h0, 32'h30, 32'h0, 32'hDEAD_BEEF, 8'hC0, 1'b1, 32'h0,
               1'b1, 1'b1, 32'h30, 32'hDEAD_BEEF, 4'hC, 2'b10, 1'b1, 32'h0, 32'h0};
    tbl[8] = '{2'b01, 2'b01, 32'h34, 32'h0, 32'h1234_5678, 32'h0, 8'h03, 1'b0, 32'h0,
               1'b1, 1'b1, 32'h34, 32'h1234_5678, 4'h3, 2'b00, 1'b0, 32'h0, 32'h0};
    tbl[9] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b01, 1'b0, 32'h0, 32'h0};

    // Reset state with traffic pending.
    set_in(2'b11, 2'b11, 2'b11, 32'h4, 32'h8, 32'h1, 32'h2, 8'hFF, 1'b1, 32'h5);
    next_cycle();
    next_cycle();
    chk("rst_slv_valid", 64'(bus.slv_valid), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_gnt", 64'(gnt_idx_o), 64'd0);
    chk("rst_lock_err", 64'(lock_err_o), 64'd0);
    rst_i = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);

    for (int k = 0; k < 10; k++) begin
      set_in(tbl[k].valid, tbl[k].write, 2'b00, tbl[k].a0, tbl[k].a1, tbl[k].wd0, tbl[k].wd1,
             tbl[k].wstrb, tbl[k].sready, tbl[k].srdata);
      #2;
      chk($sformatf("v%0d_slv_valid", k), 64'(bus.slv_valid), 64'(tbl[k].evalid));
      chk($sformatf("v%0d_slv_write", k), 64'(bus.slv_write), 64'(tbl[k].ewrite));
      chk($sformatf("v%0d_slv_addr", k), 64'(bus.slv_addr), 64'(tbl[k].eaddr));
      chk($sformatf("v%0d_slv_wdata", k), 64'(bus.slv_wdata), 64'(tbl[k].ewdata));
      chk($sformatf("v%0d_slv_wstrb", k), 64'(bus.slv_wstrb), 64'(tbl[k].ewstrb));
      chk($sformatf("v%0d_ready", k), 64'(bus.req_ready), 64'(tbl[k].eready));
      chk($sformatf("v%0d_gnt", k), 64'(gnt_idx_o), 64'(tbl[k].egnt));
      chk($sformatf("v%0d_rdata0", k), 64'(bus.req_rdata[31:0]), 64'(tbl[k].erd0));
      chk($sformatf("v%0d_rdata1", k), 64'(bus.req_rdata[63:32]), 64'(tbl[k].erd1));
      next_cycle();
    end

    // Locked 64-bit write from req1 while req0 keeps requesting (rr_ptr is 0 here).
    set_in(2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("lk_pre_gnt", 64'(gnt_idx_o), 64'd0);
    next_cycle();
    set_in(2'b11, 2'b10, 2'b10, 32'h40, 32'h20, 32'h0, 32'h1, 8'hF0, 1'b1, 32'h0);
    #2 chk("lk_lo_gnt", 64'(gnt_idx_o), 64'd1);
    chk("lk_lo_addr", 64'(bus.slv_addr), 64'h20);
    chk("lk_lo_ready", 64'(bus.req_ready), 64'b10);
    next_cycle();
    set_in(2'b11, 2'b10, 2'b00, 32'h40, 32'h24, 32'h0, 32'h2, 8'hF0, 1'b1, 32'h0);
    #2 chk("lk_hi_gnt", 64'(gnt_idx_o), 64'd1);
    chk("lk_hi_addr", 64'(bus.slv_addr), 64'h24);
    chk("lk_hi_valid", 64'(bus.slv_valid), 64'd1);
    next_cycle();
    set_in(2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("lk_after_gnt", 64'(gnt_idx_o), 64'd0);
    chk("lk_after_addr", 64'(bus.slv_addr), 64'h40);
    next_cycle();

    // Watchdog: req0 locks then goes idle; req1 must wait exactly LOCK_TIMEOUT cycles.
    set_in(2'b01, 2'b00, 2'b01, 32'h44, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("wd_lock_gnt", 64'(gnt_idx_o), 64'd0);
    next_cycle();
    for (int k = 0; k < 16; k++) begin
      set_in(2'b10, 2'b00, 2'b00, 32'h0, 32'h28, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
      #2;
      chk($sformatf("wd_hold%0d_gnt", k), 64'(gnt_idx_o), 64'd0);
      chk($sformatf("wd_hold%0d_valid", k), 64'(bus.slv_valid), 64'd0);
      chk($sformatf("wd_hold%0d_err", k), 64'(lock_err_o), 64'd0);
      next_cycle();
    end
    #2 chk("wd_fire_gnt", 64'(gnt_idx_o), 64'd1);
    chk("wd_fire_valid", 64'(bus.slv_valid), 64'd1);
    chk("wd_fire_addr", 64'(bus.slv_addr), 64'h28);
    chk("wd_fire_err", 64'(lock_err_o), 64'd1);
    next_cycle();
    set_in(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    lock_err_clr_i = 1'b1;
    next_cycle();
    lock_err_clr_i = 1'b0;
    #2 chk("wd_clr_err", 64'(lock_err_o), 64'd0);
    next_cycle();

    // Slave stall: five wait cycles with the beat held, then exactly one accept.
    for (int k = 0; k < 5; k++) begin
      set_in(2'b01, 2'b00, 2'b00, 32'h50, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);
      #2;
      chk($sformatf("st%0d_valid", k), 64'(bus.slv_valid), 64'd1);
      chk($sformatf("st%0d_addr", k), 64'(bus.slv_addr), 64'h50);
      chk($sformatf("st%0d_gnt", k), 64'(gnt_idx_o), 64'd0);
      chk($sformatf("st%0d_ready", k), 64'(bus.req_ready), 64'd0);
      next_cycle();
    end
    set_in(2'b01, 2'b00, 2'b00, 32'h50, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("st_acc_ready", 64'(bus.req_ready), 64'b01);
    next_cycle();
    set_in(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("st_rr_after", 64'(gnt_idx_o), 64'd1);
    next_cycle();

    // Watchdog fires while clear is held: set must win.
    set_in(2'b01, 2'b00, 2'b01, 32'h58, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    next_cycle();
    set_in(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    lock_err_clr_i = 1'b1;
    for (int k = 0; k < 16; k++) next_cycle();
    lock_err_clr_i = 1'b0;
    #2 chk("sw_err", 64'(lock_err_o), 64'd1);
    chk("sw_gnt", 64'(gnt_idx_o), 64'd1);
    next_cycle();

    // Reset in the middle of a locked, stalled beat.
    set_in(2'b10, 2'b00, 2'b10, 32'h0, 32'h60, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("rl_lock_gnt", 64'(gnt_idx_o), 64'd1);
    next_cycle();
    set_in(2'b11, 2'b00, 2'b00, 32'h70, 32'h64, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);
    #2 chk("rl_pre_valid", 64'(bus.slv_valid), 64'd1);
    chk("rl_pre_gnt", 64'(gnt_idx_o), 64'd1);
    rst_i = 1'b1;
    #1 chk("rl_rst_valid", 64'(bus.slv_valid), 64'd0);
    chk("rl_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rl_rst_gnt", 64'(gnt_idx_o), 64'd0);
    next_cycle();
    rst_i = 1'b0;
    set_in(2'b11, 2'b00, 2'b00, 32'h70, 32'h64, 32'h0, 32'h0, 8'h00, 1'b1, 32'h0);
    #2 chk("rl_post_gnt", 64'(gnt_idx_o), 64'd0);
    chk("rl_post_addr", 64'(bus.slv_addr), 64'h70);
    chk("rl_post_err", 64'(lock_err_o), 64'd0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
